// File: rtl/me_best_match_if.sv
// SAD-result / best-match handshake bundle between the SAD array, me_best_match and MV writeback.
// The slave modport is the me_best_match side. The master modport is the producer/consumer side.
interface me_best_match_if #(
    parameter int PIXELS_IN_BATCH = 16,
    parameter int SAD_W           = 14,
    parameter int IDX_W           = 8
);
    logic                         start;
    logic                         sad_valid;
    logic [PIXELS_IN_BATCH*SAD_W-1:0] sad_in;
    logic                         busy;
    logic                         result_valid;
    logic                         result_ready;
    logic [SAD_W-1:0]             best_sad;
    logic [IDX_W-1:0]             best_index;

    modport master (
        output start, sad_valid, sad_in, result_ready,
        input  busy, result_valid, best_sad, best_index
    );

    modport slave (
        input  start, sad_valid, sad_in, result_ready,
        output busy, result_valid, best_sad, best_index
    );
endinterface

// File: rtl/me_best_match.sv
// Reduces NUM_BATCHES batches of per-lane SADs to the overall minimum SAD and its candidate index.
// Optional macro ME_EARLY_EXIT_EN ends the search at the first accepted batch that contains a zero SAD.
module me_best_match #(
    parameter int PIXELS_IN_BATCH     = 16,
    parameter int LOG_PIXELS_IN_BATCH = 4,
    parameter int EDGE_LEN            = 8,
    parameter int LOG_EDGE_LEN        = 3,
    parameter int BIT_DEPTH           = 8,
    parameter int NUM_BATCHES         = 16,
    parameter int LOG_NUM_BATCHES     = 4,
    parameter int SAD_W               = 2*LOG_EDGE_LEN + BIT_DEPTH,
    parameter int IDX_W               = LOG_NUM_BATCHES + LOG_PIXELS_IN_BATCH
) (
    input  logic          clk,
    input  logic          rst,
    me_best_match_if.slave io_bus
);

    localparam int NODES = 2*PIXELS_IN_BATCH - 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_DONE} state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [LOG_NUM_BATCHES-1:0]     r_batch_cnt;
    logic                           r_s1_valid;
    logic [SAD_W-1:0]               r_s1_sad;
    logic [IDX_W-1:0]               r_s1_idx;
    logic [SAD_W-1:0]               r_best_sad;
    logic [IDX_W-1:0]               r_best_index;
    logic                           w_start_search;
    logic                           w_accept;
    logic                           w_cnt_last;
    logic                           w_last;
    logic                           w_busy;
    logic                           w_result_valid;
    logic [SAD_W-1:0]               w_node_sad  [NODES];
    logic [LOG_PIXELS_IN_BATCH-1:0] w_node_lane [NODES];

    // The min tree relies on a complete binary heap, so the lane count must be a power of two.
    a_params_pow2: assert property (@(posedge clk)
        (EDGE_LEN == (1 << LOG_EDGE_LEN)) && (PIXELS_IN_BATCH == (1 << LOG_PIXELS_IN_BATCH)));

    assign w_start_search = (r_state == S_IDLE) && io_bus.start;
    assign w_accept       = (r_state == S_COLLECT) && io_bus.sad_valid;
    assign w_cnt_last     = (r_batch_cnt == LOG_NUM_BATCHES'(NUM_BATCHES - 1));

`ifdef ME_EARLY_EXIT_EN
    logic w_zero_seen;
    assign w_zero_seen = (w_node_sad[0] == '0);
    assign w_last      = w_cnt_last || w_zero_seen;
`else
    assign w_last      = w_cnt_last;
`endif

    // Heap-ordered min tree: leaves hold lanes in order, and the left child wins ties (lower lane).
    always_comb begin
        for (int k = 0; k < PIXELS_IN_BATCH; k++) begin
            w_node_sad[PIXELS_IN_BATCH-1+k]  = io_bus.sad_in[k*SAD_W +: SAD_W];
            w_node_lane[PIXELS_IN_BATCH-1+k] = LOG_PIXELS_IN_BATCH'(k);
        end
        for (int n = PIXELS_IN_BATCH - 2; n >= 0; n--) begin
            if (w_node_sad[2*n+2] < w_node_sad[2*n+1]) begin
                w_node_sad[n]  = w_node_sad[2*n+2];
                w_node_lane[n] = w_node_lane[2*n+2];
            end else begin
                w_node_sad[n]  = w_node_sad[2*n+1];
                w_node_lane[n] = w_node_lane[2*n+1];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: the default assignment first keeps this combinational block from inferring a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (io_bus.start)           w_state_next = S_COLLECT;
            S_COLLECT: if (w_accept && w_last)     w_state_next = S_FLUSH;
            S_FLUSH:                               w_state_next = S_DONE;
            S_DONE:    if (io_bus.result_ready)    w_state_next = S_IDLE;
            default:                               w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy         = (r_state != S_IDLE);
        w_result_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_batch_cnt <= '0;
        end else if (w_start_search) begin
            r_batch_cnt <= '0;
        end else if (w_accept && !w_cnt_last) begin
            r_batch_cnt <= r_batch_cnt + 1'b1;
        end
    end

    // Stage 1: register the batch minimum with its global index {batch, lane}.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sad   <= '0;
            r_s1_idx   <= '0;
        end else begin
            r_s1_valid <= w_accept && !w_start_search;
            if (w_accept) begin
                r_s1_sad <= w_node_sad[0];
                r_s1_idx <= {r_batch_cnt, w_node_lane[0]};
            end
        end
    end

    // Stage 2: strict compare, so an equal later candidate never displaces an earlier index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_best_sad   <= '1;
            r_best_index <= '0;
        end else if (w_start_search) begin
            r_best_sad   <= '1;
            r_best_index <= '0;
        end else if (r_s1_valid && (r_s1_sad < r_best_sad)) begin
            r_best_sad   <= r_s1_sad;
            r_best_index <= r_s1_idx;
        end
    end

    assign io_bus.busy         = w_busy;
    assign io_bus.result_valid = w_result_valid;
    assign io_bus.best_sad     = r_best_sad;
    assign io_bus.best_index   = r_best_index;

endmodule

// File: tb/tb_me_best_match.sv
// Scoreboard bench for me_best_match; compile with +define+ME_EARLY_EXIT_EN to match an early-exit DUT.
module tb_me_best_match;

    localparam int P     = 16;
    localparam int NB    = 16;
    localparam int SAD_W = 14;
    localparam int IDX_W = 8;

    typedef struct packed {
        logic [SAD_W-1:0] sad;
        logic [IDX_W-1:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    logic [SAD_W-1:0] sads [NB][P];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    me_best_match_if #(.PIXELS_IN_BATCH(P), .SAD_W(SAD_W), .IDX_W(IDX_W)) bus ();

    me_best_match u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [SAD_W-1:0] v);
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < P; k++) sads[b][k] = v;
    endtask

    task automatic fill_random();
        for (int b = 0; b < NB; b++)
            for (int k = 0; k < P; k++) sads[b][k] = SAD_W'($urandom_range(2, 16000));
    endtask

    function automatic logic [P*SAD_W-1:0] pack(input int b);
        logic [P*SAD_W-1:0] v;
        v = '0;
        for (int k = 0; k < P; k++) v[k*SAD_W +: SAD_W] = sads[b][k];
        return v;
    endfunction

    // Reference: scan candidates in index order, keep the first strict minimum.
    task automatic model(output exp_t e, output int last);
        e.sad = '1;
        e.idx = '0;
        last  = NB - 1;
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < P; k++) begin
                if (sads[b][k] < e.sad) begin
                    e.sad = sads[b][k];
                    e.idx = IDX_W'(b*P + k);
                end
            end
`ifdef ME_EARLY_EXIT_EN
            if (e.sad == '0) begin
                last = b;
                break;
            end
`endif
        end
    endtask

    task automatic run_search(input int gap_max, input int hold);
        exp_t e;
        exp_t want;
        int   last;
        int   cyc;
        model(e, last);
        sb.push_back(e);
        // Zero beats while IDLE must not leak into the search.
        bus.sad_valid = 1'b1;
        bus.sad_in    = '0;
        step();
        step();
        check("idle_busy", 32'(bus.busy), 0);
        bus.sad_valid = 1'b0;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        check("start_busy", 32'(bus.busy), 1);
        for (int b = 0; b <= last; b++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    bus.sad_valid = 1'b0;
                    bus.sad_in    = '0;
                    step();
                end
            end
            bus.sad_valid = 1'b1;
            bus.sad_in    = pack(b);
            step();
        end
        // Final batch accepted; zero beats now arrive in FLUSH and DONE.
        bus.sad_valid = 1'b1;
        bus.sad_in    = '0;
        check("flush_valid", 32'(bus.result_valid), 0);
        cyc = 0;
        while (!bus.result_valid && cyc < 8) begin
            step();
            cyc++;
        end
        check("latency", 32'(cyc), 1);
        want = sb.pop_front();
        check("best_sad", 32'(bus.best_sad), 32'(want.sad));
        check("best_index", 32'(bus.best_index), 32'(want.idx));
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_valid", 32'(bus.result_valid), 1);
            check("hold_sad", 32'(bus.best_sad), 32'(want.sad));
            check("hold_index", 32'(bus.best_index), 32'(want.idx));
        end
        bus.sad_valid    = 1'b0;
        bus.result_ready = 1'b1;
        bus.start        = 1'b1;
        step();
        bus.result_ready = 1'b0;
        bus.start        = 1'b0;
        check("ack_busy", 32'(bus.busy), 0);
        check("ack_valid", 32'(bus.result_valid), 0);
        step();
        check("start_ignored", 32'(bus.busy), 0);
    endtask

    task automatic reset_mid_collect();
        fill_random();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            bus.sad_valid = 1'b1;
            bus.sad_in    = pack(b);
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_valid", 32'(bus.result_valid), 0);
        check("rst_sad", 32'(bus.best_sad), 32'h3FFF);
        check("rst_index", 32'(bus.best_index), 0);
        bus.sad_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("post_rst_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.sad_valid    = 1'b0;
        bus.sad_in       = '0;
        bus.result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_valid", 32'(bus.result_valid), 0);
        check("reset_sad", 32'(bus.best_sad), 32'h3FFF);
        check("reset_index", 32'(bus.best_index), 0);
        rst = 1'b0;
        step();

        // Single minimum of 42 at index 115, result held for 10 cycles.
        fill(14'd100);
        sads[7][3] = 14'd42;
        run_search(0, 10);

        // Three ties of 10; the lowest index (37) wins.
        fill(14'd100);
        sads[2][5]  = 14'd10;
        sads[2][9]  = 14'd10;
        sads[12][0] = 14'd10;
        run_search(0, 0);

        // Random data with sad_valid gaps; unique minimum 1 at index 200.
        fill_random();
        sads[12][8] = 14'd1;
        run_search(3, 1);

        // Zero at batch 3 lane 2 (index 50).
        fill(14'd100);
        sads[3][2] = 14'd0;
        run_search(0, 0);

        reset_mid_collect();
        fill_random();
        run_search(2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
